// File: rtl/mixer_pkg.sv
// mixer_pkg: shared types and constants for the channel mixer and the
// sample saturator (which the I2S output stage also uses).
//   MixerState   : mixer sequencing states
//   SAMPLE_MAX   : largest 16-bit signed sample
//   SAMPLE_MIN   : smallest 16-bit signed sample
//   VOLUME_UNITY : master volume code for unity gain (Q1.7)
package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } MixerState;

   localparam int SAMPLE_MAX   = 32767;
   localparam int SAMPLE_MIN   = -32768;
   localparam int VOLUME_UNITY = 128;

endpackage

// File: rtl/sample_saturator.sv
// sample_saturator: clamps a wide signed value to the 16-bit sample range.
// Purely combinational.
//   IN_W      : input width in bits (>= 16)
//   value     : signed input
//   saturated : signed 16-bit result, clamped to SAMPLE_MAX / SAMPLE_MIN
module sample_saturator
   import mixer_pkg::*;
#(
   parameter int IN_W = 17
) (
   input  logic signed [IN_W-1:0] value,
   output logic signed [15:0]     saturated
);

   localparam logic signed [IN_W-1:0] MAX_W = IN_W'(SAMPLE_MAX);
   localparam logic signed [IN_W-1:0] MIN_W = IN_W'(SAMPLE_MIN);

   always_comb begin
      saturated = value[15:0];
      if (value > MAX_W) begin
         saturated = 16'sh7FFF;
      end else if (value < MIN_W) begin
         saturated = 16'sh8000;
      end
   end

endmodule

// File: rtl/channel_mixer.sv
// channel_mixer: snapshots all channel samples on an lrclk rising edge, sums
// the enabled ones one channel per clock, saturates to 16 bits and presents
// the mix with a one-cycle valid pulse.
// Optional build macro MIXER_MASTER_VOLUME_EN adds an 8-bit master volume
// (128 = unity) applied to the sum before saturation.
//   clk             : system clock
//   rst             : synchronous active-high reset
//   lrclk           : I2S word clock, synchronous to clk
//   i_samples       : channel k sample at [16k+15:16k], signed
//   i_channelEnable : bit k enables channel k
//   i_masterVolume  : (MIXER_MASTER_VOLUME_EN only) unsigned Q1.7 gain
//   o_mixedSample   : saturated mix, held between mixes
//   o_mixValid      : one-cycle pulse when o_mixedSample updates
//   o_busy          : mix in progress
//   o_overrun       : sticky, lrclk edge seen while busy
//
// state  | meaning
// IDLE   | waiting for lrclk rising edge
// ACCUM  | adding shadow[idx] into acc, one channel per clock
// OUTPUT | result and valid pulse presented, back to IDLE next
module channel_mixer
   import mixer_pkg::*;
#(
   parameter  int CHANNEL_COUNT = 8,
   localparam int ACC_W         = 16 + $clog2(CHANNEL_COUNT) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        lrclk,
   input  logic [16*CHANNEL_COUNT-1:0] i_samples,
   input  logic [CHANNEL_COUNT-1:0]    i_channelEnable,
`ifdef MIXER_MASTER_VOLUME_EN
   input  logic [7:0]                  i_masterVolume,
`endif
   output logic [15:0]                 o_mixedSample,
   output logic                        o_mixValid,
   output logic                        o_busy,
   output logic                        o_overrun
);

   localparam int IDX_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_COUNT - 1);

   MixerState                   state;
   logic                        oldLrclk;
   logic                        lrEdge;
   logic [16*CHANNEL_COUNT-1:0] shadowSamples;
   logic [CHANNEL_COUNT-1:0]    shadowEnable;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     accNext;
   logic signed [ACC_W-1:0]     term;
   logic [IDX_W-1:0]            idx;
   logic [15:0]                 curSample;
   logic signed [15:0]          satOut;

   assign lrEdge    = ~oldLrclk & lrclk;
   assign curSample = shadowSamples[16*idx +: 16];

   always_comb begin
      term = '0;
      if (shadowEnable[idx]) begin
         term = {{(ACC_W-16){curSample[15]}}, curSample};
      end
   end

   // The final channel is folded in combinationally so the result can be
   // registered together with the valid pulse on entry to OUTPUT.
   assign accNext = acc + term;

`ifdef MIXER_MASTER_VOLUME_EN
   logic [7:0]              volShadow;
   logic signed [ACC_W+8:0] accWide;
   logic signed [ACC_W+8:0] volWide;
   logic signed [ACC_W+8:0] scaled;

   assign accWide = {{9{accNext[ACC_W-1]}}, accNext};
   assign volWide = {{(ACC_W+1){1'b0}}, volShadow};
   assign scaled  = (accWide * volWide) >>> 7;

   sample_saturator #(.IN_W(ACC_W + 9)) uSat (
      .value     (scaled),
      .saturated (satOut)
   );
`else
   sample_saturator #(.IN_W(ACC_W)) uSat (
      .value     (accNext),
      .saturated (satOut)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         oldLrclk      <= 1'b0;
         shadowSamples <= '0;
         shadowEnable  <= '0;
         acc           <= '0;
         idx           <= '0;
         o_mixedSample <= '0;
         o_mixValid    <= 1'b0;
         o_busy        <= 1'b0;
         o_overrun     <= 1'b0;
`ifdef MIXER_MASTER_VOLUME_EN
         volShadow     <= 8'(VOLUME_UNITY);
`endif
      end else begin
         oldLrclk   <= lrclk;
         o_mixValid <= 1'b0;
         if (lrEdge && (state != IDLE)) begin
            o_overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (lrEdge) begin
                  shadowSamples <= i_samples;
                  shadowEnable  <= i_channelEnable;
`ifdef MIXER_MASTER_VOLUME_EN
                  volShadow     <= i_masterVolume;
`endif
                  acc           <= '0;
                  idx           <= '0;
                  o_busy        <= 1'b1;
                  state         <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= accNext;
               idx <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  o_mixedSample <= satOut;
                  o_mixValid    <= 1'b1;
                  state         <= OUTPUT;
               end
            end
            OUTPUT: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_channel_mixer.sv
// tb_channel_mixer: directed self-checking bench for channel_mixer with
// CHANNEL_COUNT = 8. Build with MIXER_MASTER_VOLUME_EN to also exercise the
// master volume path.
module tb_channel_mixer;

   logic         clk = 1'b0;
   logic         rst;
   logic         lrclk;
   logic [127:0] i_samples;
   logic [7:0]   i_channelEnable;
   logic [7:0]   i_masterVolume;
   logic [15:0]  o_mixedSample;
   logic         o_mixValid;
   logic         o_busy;
   logic         o_overrun;

   int tests  = 0;
   int failed = 0;

   channel_mixer #(.CHANNEL_COUNT(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .lrclk           (lrclk),
      .i_samples       (i_samples),
      .i_channelEnable (i_channelEnable),
`ifdef MIXER_MASTER_VOLUME_EN
      .i_masterVolume  (i_masterVolume),
`endif
      .o_mixedSample   (o_mixedSample),
      .o_mixValid      (o_mixValid),
      .o_busy          (o_busy),
      .o_overrun       (o_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input logic signed [31:0] obs, input logic signed [31:0] exp,
                        input string tag);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] packRamp(input int base, input int step);
      logic [127:0] s;
      for (int i = 0; i < 8; i++) s[16*i +: 16] = 16'(base + step * i);
      return s;
   endfunction

   function automatic logic [127:0] packAlt(input int even, input int odd);
      logic [127:0] s;
      for (int i = 0; i < 8; i++) s[16*i +: 16] = (i % 2 == 0) ? 16'(even) : 16'(odd);
      return s;
   endfunction

   // mode 0: plain mix; 1: live inputs zeroed at E+2; 2: second edge at E+4;
   // 3: rst asserted at E+3.
   int validCnt, validAt, busyCnt;
   logic signed [31:0] mixAtValid;

   task automatic runMix(input logic [127:0] samp, input logic [7:0] en,
                         input logic [7:0] vol, input int mode);
      validCnt   = 0;
      validAt    = -1;
      busyCnt    = 0;
      mixAtValid = 32'sh7FFF_FFFF;
      @(negedge clk);
      i_samples       = samp;
      i_channelEnable = en;
      i_masterVolume  = vol;
      lrclk           = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (o_mixValid) begin
            validCnt++;
            validAt    = c;
            mixAtValid = 32'($signed(o_mixedSample));
         end
         if (o_busy) busyCnt++;
         if (c == 1) lrclk = 1'b0;
         if (mode == 1 && c == 2) begin
            i_samples       = '0;
            i_channelEnable = '0;
            i_masterVolume  = 8'd0;
         end
         if (mode == 2 && c == 3) lrclk = 1'b1;
         if (mode == 2 && c == 4) lrclk = 1'b0;
         if (mode == 3 && c == 3) rst = 1'b1;
         if (mode == 3 && c == 4) rst = 1'b0;
      end
   endtask

   initial begin
      rst             = 1'b1;
      lrclk           = 1'b0;
      i_samples       = '0;
      i_channelEnable = '0;
      i_masterVolume  = 8'd128;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(32'(o_mixedSample), 0, "reset_mixedSample");
      check(32'(o_mixValid),    0, "reset_mixValid");
      check(32'(o_busy),        0, "reset_busy");
      check(32'(o_overrun),     0, "reset_overrun");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      runMix(packRamp(100, 100), 8'hFF, 8'd128, 0);
      check(validCnt, 1, "ramp_valid_count");
      check(validAt, 9, "ramp_latency");
      check(busyCnt, 9, "ramp_busy_cycles");
      check(mixAtValid, 3600, "ramp_sum");
      check(32'($signed(o_mixedSample)), 3600, "ramp_held");
      check(32'(o_overrun), 0, "ramp_no_overrun");

      runMix(packRamp(30000, 0), 8'hFF, 8'd128, 0);
      check(mixAtValid, 32767, "sat_positive");
      runMix(packRamp(-30000, 0), 8'hFF, 8'd128, 0);
      check(mixAtValid, -32768, "sat_negative");
      runMix(packAlt(32767, -32768), 8'hFF, 8'd128, 0);
      check(mixAtValid, -4, "no_intermediate_clamp");

      runMix(packRamp(1000, 0), 8'b0000_0101, 8'd128, 0);
      check(mixAtValid, 2000, "enable_mask");
      runMix(packRamp(1000, 0), 8'b0000_0101, 8'd128, 1);
      check(mixAtValid, 2000, "shadow_isolation");
      check(validCnt, 1, "shadow_valid_count");

      runMix(packRamp(1234, 0), 8'h00, 8'd128, 0);
      check(validCnt, 1, "all_disabled_valid");
      check(mixAtValid, 0, "all_disabled_sum");

      runMix(packRamp(100, 100), 8'hFF, 8'd128, 2);
      check(validCnt, 1, "overrun_single_valid");
      check(validAt, 9, "overrun_latency");
      check(mixAtValid, 3600, "overrun_sum");
      check(32'(o_overrun), 1, "overrun_set");
      runMix(packRamp(1000, 0), 8'h0F, 8'd128, 0);
      check(32'(o_overrun), 1, "overrun_sticky");
      check(mixAtValid, 4000, "after_overrun_sum");

      runMix(packRamp(30000, 0), 8'hFF, 8'd128, 3);
      check(validCnt, 0, "reset_abort_no_valid");
      check(32'(o_mixedSample), 0, "reset_abort_sample");
      check(32'(o_overrun), 0, "reset_clears_overrun");
      check(32'(o_busy), 0, "reset_abort_idle");
      runMix(packRamp(1000, 0), 8'hFF, 8'd128, 0);
      check(validCnt, 1, "post_reset_valid");
      check(mixAtValid, 8000, "post_reset_sum");

`ifdef MIXER_MASTER_VOLUME_EN
      runMix(packRamp(20000, 0), 8'b0000_0001, 8'd64, 0);
      check(mixAtValid, 10000, "vol_half");
      runMix(packRamp(20000, 0), 8'b0000_0001, 8'd255, 0);
      check(mixAtValid, 32767, "vol_max_sat");
      runMix(packRamp(20000, 0), 8'b0000_0001, 8'd128, 0);
      check(mixAtValid, 20000, "vol_unity");
      runMix(packRamp(-20000, 0), 8'b0000_0001, 8'd64, 1);
      check(mixAtValid, -10000, "vol_shadowed");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/channel_mixer.md
Name: channel_mixer

Overview:
- Sits directly downstream of the per-channel sample generators in the audio system.
- Snapshots every channel's 16-bit signed sample on the rising edge of lrclk.
- Sums the enabled channels sequentially, one channel per clock, into a wide accumulator.
- Saturates the sum to 16 bits and presents one mixed sample plus a one-cycle valid pulse to the I2S output stage.

Parameters:
- CHANNEL_COUNT, 8, number of channel inputs; legal range 1..32.
- ACC_W, 16+$clog2(CHANNEL_COUNT)+1, accumulator width in bits; derived, not overridden.

Ports:
- clk  input  1  system clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- lrclk  input  1  I2S word clock, already synchronous to clk
- i_samples  input  16*CHANNEL_COUNT  channel k sample at bits [16k+15:16k], signed
- i_channelEnable  input  CHANNEL_COUNT  bit k=1 means channel k contributes to the mix
- o_mixedSample  output  16  saturated signed mix; held between mixes
- o_mixValid  output  1  one-cycle pulse when o_mixedSample updates
- o_busy  output  1  high while a mix is in progress
- o_overrun  output  1  sticky flag: an lrclk rising edge arrived while busy

Behaviour:
- Edge detect: old_lrclk is registered every cycle. An edge is the cycle with old_lrclk==0 && lrclk==1 (call it cycle E).
- At E, in IDLE:
  - capture i_samples and i_channelEnable into shadow registers;
  - clear the accumulator and set channel index to 0;
  - go to ACCUM.
  - The snapshot takes the pre-edge values, i.e. the samples the channels commit at that same edge.
- ACCUM, cycles E+1..E+CHANNEL_COUNT:
  - acc += sign-extended shadow[idx] if enable[idx], else += 0;
  - idx++;
  - when idx==CHANNEL_COUNT-1 has been added, go to OUTPUT.
- OUTPUT, cycle E+CHANNEL_COUNT+1:
  - o_mixedSample <= sat16(acc), with sat16 = 32767 if acc>32767, -32768 if acc<-32768, else acc[15:0];
  - o_mixValid=1 for this cycle only;
  - return to IDLE.
- Latency: edge to valid is CHANNEL_COUNT+1 cycles.
- o_busy=1 in ACCUM and OUTPUT; 0 in IDLE.
- Edge while busy: ignored and no restart; the mix in progress completes; o_overrun <= 1.
- o_overrun clears only on rst.
- Changes to the live inputs after E do not affect the running mix (shadow only).
- All channels disabled: the result is 0 and valid still pulses.
- Reset values: o_mixedSample=0, o_mixValid=0, o_busy=0, o_overrun=0, state=IDLE, old_lrclk=0, acc=0, idx=0.
- Reset mid-mix: abort immediately; no valid pulse is produced for the aborted mix.
- Reset asserted in the same cycle as an edge: reset wins and the edge is lost.
- Accumulator width ACC_W guarantees no internal wrap for CHANNEL_COUNT full-scale inputs.

Optional Feature:
- Macro: MIXER_MASTER_VOLUME_EN.
- Defined:
  - adds port i_masterVolume input 8, unsigned, where 128 = unity and 255 ≈ 2x;
  - the value is captured at E with the other shadow registers;
  - in OUTPUT, scaled = (acc * $signed({1'b0,vol})) >>> 7 at ACC_W+9 bits, then sat16(scaled);
  - latency is unchanged.
- Undefined: the port is absent and the result is sat16(acc) (unity gain).

Decomposition:
- Package mixer_pkg:
  - MixerState enum (IDLE, ACCUM, OUTPUT) as logic[1:0];
  - SAMPLE_MAX=32767, SAMPLE_MIN=-32768;
  - VOLUME_UNITY=128.
- Sub-module sample_saturator:
  - parameterised input width;
  - signed in, 16-bit signed out, clamped to SAMPLE_MAX/SAMPLE_MIN;
  - combinational; also reused by the I2S stage.

Test Plan:
- CHANNEL_COUNT=8, samples 100,200,...,800, all enabled, one edge:
  - o_mixValid exactly 9 cycles after E;
  - o_mixedSample=3600;
  - o_busy high for 9 cycles.
- All 8 channels=30000, all enabled → 32767. All 8=-30000 → -32768. Values alternate +32767/-32768 → -4 (no intermediate clamp).
- Samples 1000 each, i_channelEnable=8'b0000_0101 → 2000. Inputs changed to 0 at E+2 → still 2000.
- Second edge at E+4 → mix completes normally, o_overrun=1 and stays 1 until rst; no second valid pulse.
- rst asserted at E+3 → no valid pulse; o_mixedSample=0; next edge mixes correctly from a clean accumulator.
- With MIXER_MASTER_VOLUME_EN, vol=64 and single channel 20000 → 10000. vol=255 and 20000 → 32767. vol=128 and 20000 → 20000.
